uart_tx: RTL and testbench

UART transmitter, the transmit end of the serial link whose receiver samples RX at 16 clocks per bit.
- Serialises parallel bytes into frames: start(0), 8 data bits LSB first, optional parity, stop(1). Idle line is 1.
- Accepts bytes over a valid/ready handshake. A one-entry holding register allows back-to-back frames with no idle gap.
- Default frame is 11 bits with even parity, matching the receiver.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// A one-entry holding register behind a valid/ready handshake lets frames run back to back.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  tx_ready,
  output logic                  TX,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      clk_cnt_reg, clk_cnt_next;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_reg, parity_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic                  hold_full_reg, hold_full_next;
  logic                  tx_next, busy_next, done_next;
  logic                  last_tick;
  logic                  load;

  assign tx_ready  = ~hold_full_reg;
  assign last_tick = (clk_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      clk_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      TX            <= 1'b1;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      TX            <= tx_next;
      busy          <= busy_next;
      tx_done       <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = clk_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          state_next   = START;
          clk_cnt_next = '0;
          load         = 1'b1;
        end
      end
      START: begin
        if (last_tick) begin
          state_next   = DATA;
          clk_cnt_next = '0;
          bit_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          clk_cnt_next = '0;
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = PAR_EN ? PARITY : STOP;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_next   = STOP;
          clk_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          clk_cnt_next = '0;
          // A waiting byte goes straight into the next start bit with no idle gap.
          if (hold_full_reg) begin
            state_next = START;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
      end
    endcase

    if (load) begin
      shift_next     = hold_reg;
      parity_next    = (^hold_reg) ^ PAR_ODD;
      hold_full_next = 1'b0;
    end

    // Acceptance depends only on the pre-edge empty flag, so it never collides with load.
    if (data_valid && !hold_full_reg) begin
      hold_next      = data_in;
      hold_full_next = 1'b1;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && (clk_cnt_next == CNT_LAST);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model checks the default instance every cycle,
// and literal frame patterns pin the model and three small-bit-period variants.
module tb_uart_tx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       dv0 = 1'b0, dv1 = 1'b0, dv2 = 1'b0, dv3 = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00, din2 = 8'h00, din3 = 8'h00;
  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic       ready0, ready1, ready2, ready3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx u_main (
    .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
    .tx_ready(ready0), .TX(tx0), .busy(busy0), .tx_done(done0)
  );
  uart_tx #(.CLKS_PER_BIT(4)) u_even4 (
    .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv1),
    .tx_ready(ready1), .TX(tx1), .busy(busy1), .tx_done(done1)
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd4 (
    .clk(clk), .rst(rst), .data_in(din2), .data_valid(dv2),
    .tx_ready(ready2), .TX(tx2), .busy(busy2), .tx_done(done2)
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_nopar4 (
    .clk(clk), .rst(rst), .data_in(din3), .data_valid(dv3),
    .tx_ready(ready3), .TX(tx3), .busy(busy3), .tx_done(done3)
  );

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line model of the default instance ----------------
  bit         line_q[$];
  bit         last_q[$];
  logic       m_hold_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;

  // Expand a byte into the per-clock line samples of its whole frame.
  function automatic void expand(input logic [7:0] b);
    bit fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(b[i]);
    fb.push_back(^b);
    fb.push_back(1'b1);
    for (int i = 0; i < fb.size(); i++)
      for (int c = 0; c < CPB; c++) begin
        line_q.push_back(fb[i]);
        last_q.push_back((i == fb.size() - 1) && (c == CPB - 1));
      end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q.delete();
      last_q.delete();
      m_hold_full = 1'b0;
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      logic acc;
      acc = dv0 && !m_hold_full;
      if (line_q.size() == 0 && m_hold_full) begin
        expand(m_hold);
        m_hold_full = 1'b0;
      end
      if (line_q.size() > 0) begin
        m_tx   = line_q.pop_front();
        m_done = last_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_done = 1'b0;
        m_busy = 1'b0;
      end
      if (acc) begin
        m_hold = din0;
        m_hold_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    checkb("tx", tx0, m_tx);
    checkb("busy", busy0, m_busy);
    checkb("tx_done", done0, m_done);
    checkb("tx_ready", ready0, !m_hold_full);
  end

  // ---------------- helpers ----------------
  function automatic logic get_tx(input int s);
    case (s)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic logic get_done(input int s);
    case (s)
      0: return done0;
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic get_ready(input int s);
    case (s)
      0: return ready0;
      1: return ready1;
      2: return ready2;
      default: return ready3;
    endcase
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] b);
    case (s)
      0: begin dv0 = v; din0 = b; end
      1: begin dv1 = v; din1 = b; end
      2: begin dv2 = v; din2 = b; end
      default: begin dv3 = v; din3 = b; end
    endcase
  endtask

  // Call at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input int s, input logic [7:0] b);
    int n = 0;
    while (!get_ready(s) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkb("ready_before_send", get_ready(s), 1'b1);
    drive(s, 1'b1, b);
    @(negedge clk);
    drive(s, 1'b0, 8'h00);
  endtask

  // Waits for a start bit, then samples mid-bit and records the tx_done cycle (start cycle = 1).
  task automatic capture(input int s, input int cpb, output logic [11:0] bits,
                         output int done_cyc, output int waited);
    bits = '0;
    done_cyc = 0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (get_tx(s) !== 1'b0 && waited < 400);
    checkb("start_bit_seen", get_tx(s), 1'b0);
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge clk);
      if (((c - 1) % cpb) == cpb / 2 && ((c - 1) / cpb) < 12) bits[(c - 1) / cpb] = get_tx(s);
      if (get_done(s)) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  logic [11:0] bits_a, bits_b;
  int          dc_a, dc_b, w_a, w_b, n_hs, n_low;

  initial begin
    repeat (3) @(negedge clk);
    checkb("reset_tx", tx0, 1'b1);
    checkb("reset_busy", busy0, 1'b0);
    checkb("reset_ready", ready0, 1'b1);
    checkb("reset_done", done0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame of A7: start, A7 LSB first, even parity 1, stop.
    send(0, 8'hA7);
    capture(0, CPB, bits_a, dc_a, w_a);
    checki("a7_latency", w_a, 1);
    checki("a7_frame", int'(bits_a), 32'h74E);
    checki("a7_done_cycle", dc_a, 176);
    $display("frame A7: bits=%03h done_cycle=%0d", bits_a, dc_a);
    @(negedge clk);

    // B2 then 4D accepted while busy: second frame follows with no idle bit.
    fork
      begin
        send(0, 8'hB2);
        repeat (20) @(negedge clk);
        send(0, 8'h4D);
        checkb("ready_low_while_held", ready0, 1'b0);
      end
      capture(0, CPB, bits_a, dc_a, w_a);
    join
    capture(0, CPB, bits_b, dc_b, w_b);
    checki("b2_frame", int'(bits_a), 32'h564);
    checki("b2_done_cycle", dc_a, 176);
    checki("b2b_gap", w_b, 1);
    checki("4d_frame", int'(bits_b), 32'h49A);
    checki("4d_done_cycle", dc_b, 176);
    $display("frames B2/4D: bits=%03h/%03h gap=%0d", bits_a, bits_b, w_b);
    @(negedge clk);

    // data_valid held with 55 for 200 cycles: handshakes at +0, +2, +178.
    drive(0, 1'b1, 8'h55);
    n_hs = 0;
    for (int i = 0; i < 200; i++) begin
      if (ready0) n_hs++;
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    checki("held_valid_transfers", n_hs, 3);
    $display("held valid: transfers=%0d", n_hs);
    n_low = 0;
    while (!(busy0 == 1'b0 && ready0 == 1'b1) && n_low < 1000) begin
      @(negedge clk);
      n_low++;
    end
    checkb("drain_idle", busy0, 1'b0);

    // Reset mid-frame with a byte held: line returns high immediately and stays quiet.
    send(0, 8'h3C);
    repeat (5) @(negedge clk);
    send(0, 8'hC3);
    repeat (42) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkb("async_rst_tx", tx0, 1'b1);
    checkb("async_rst_busy", busy0, 1'b0);
    checkb("async_rst_ready", ready0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx0 !== 1'b1) n_low++;
    end
    checki("post_reset_quiet", n_low, 0);
    $display("reset mid-frame: low cycles after release=%0d", n_low);

    // Four-clock bit variants.
    send(1, 8'h01);
    capture(1, 4, bits_a, dc_a, w_a);
    checki("even4_frame", int'(bits_a), 32'h602);
    checki("even4_done_cycle", dc_a, 44);
    $display("even4 01: bits=%03h done_cycle=%0d", bits_a, dc_a);
    @(negedge clk);
    send(2, 8'h00);
    capture(2, 4, bits_a, dc_a, w_a);
    checki("odd4_frame", int'(bits_a), 32'h600);
    checki("odd4_done_cycle", dc_a, 44);
    $display("odd4 00: bits=%03h done_cycle=%0d", bits_a, dc_a);
    @(negedge clk);
    send(3, 8'hFF);
    capture(3, 4, bits_a, dc_a, w_a);
    checki("nopar4_frame", int'(bits_a), 32'h3FE);
    checki("nopar4_done_cycle", dc_a, 40);
    $display("nopar4 FF: bits=%03h done_cycle=%0d", bits_a, dc_a);
    @(negedge clk);

    // Random traffic on the default instance; data_in churns every cycle.
    for (int i = 0; i < 6000; i++) begin
      dv0  = ($urandom_range(0, 5) == 0);
      din0 = 8'($urandom);
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    repeat (400) @(negedge clk);
    checkb("final_idle", busy0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
